dsp_mac_sequencer: RTL and testbench
====================================

Name: dsp_mac_sequencer

Overview:
- Initiator-side controller that drives a DSP48A1 slice wrapper as a multiply-accumulate engine.
- Accepts a job (length N), streams N signed 18x18 operand pairs into the slice's A/B ports, and generates OPMODE so that the first product loads P and later products accumulate.
- Waits out the slice pipeline, captures P, and returns the 48-bit dot product over a valid/ready result port.
- Sits between the datapath operand FIFOs and one DSP slice instance.

Parameters:
- LEN_W, 8, width of the job length; max N = 2^LEN_W-1.
- DSP_LAT, 3, cycles from an operand issue cycle until the corresponding P is valid on DSP_P (AREG/BREG=1, MREG=1, PREG=1).
- OPM_DLY, 2, cycles OPMODE is delayed relative to A/B so that it aligns with M at the post-adder; 0..DSP_LAT-1.

Ports:
- CLK  in  1  clock; all state on rising edge.
- RSTN  in  1  asynchronous active-low reset.
- start  in  1  job request; sampled only in IDLE.
- len  in  LEN_W  number of operand pairs, sampled with start.
- busy  out  1  high in every state except IDLE.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  operand pair accepted when in_valid&in_ready.
- in_a  in  18  signed operand A.
- in_b  in  18  signed operand B.
- DSP_A  out  18  to slice A, registered.
- DSP_B  out  18  to slice B, registered.
- DSP_OPMODE  out  8  to slice OPMODE, registered.
- DSP_CE  out  1  common CE for A/B/M/P/OPMODE registers.
- DSP_RSTP  out  1  synchronous P reset pulse to slice.
- DSP_P  in  48  slice P output.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumer ready.
- result  out  48  captured dot product.

Behaviour:
- Reset (RSTN=0, any time, mid-job included):
  - state=IDLE; all counters 0.
  - DSP_A=0, DSP_B=0, DSP_OPMODE=0.
  - DSP_CE=0, DSP_RSTP=0.
  - in_ready=0, res_valid=0, result=0, busy=0.
  - Any in-flight job is discarded.
- FSM states: IDLE, CLEAR, RUN, DRAIN, DONE.
- IDLE:
  - start=1 and len!=0: latch len, pulse DSP_RSTP=1 for one cycle, go to CLEAR.
  - start=1 and len=0: result=0, go to DONE.
- CLEAR: DSP_CE=1 from here until the end of DRAIN; go to RUN.
- RUN:
  - in_ready=1 while issued<len.
  - Accept cycle: DSP_A/DSP_B <= in_a/in_b. OPMODE <= 8'h01 (X=M, Z=0) for the first pair, else 8'h09 (X=M, Z=P). OPMODE passes through an OPM_DLY-stage delay line. issued++.
  - Bubble cycle (in_valid=0): DSP_A=DSP_B=0 with OPMODE 8'h09, which adds zero. If the first pair is not yet accepted, OPMODE is 8'h01, which loads zero.
  - Issue cycle of the last pair (issued reaches len): go to DRAIN and load drain counter = DSP_LAT.
- DRAIN:
  - Issue zero operands with OPMODE 8'h09; in_ready=0.
  - Decrement each cycle. At 0, capture result<=DSP_P (the cycle exactly DSP_LAT after the last issue), then go to DONE.
- DONE:
  - res_valid=1; result stable; DSP_CE=0.
  - On res_valid&res_ready: res_valid=0 and go to IDLE the next cycle.
  - start in DONE is ignored.
- Arithmetic: products are 36-bit signed and sign-extended by the slice. The sum wraps modulo 2^48 with no saturation. CARRYIN is not used (OPMODE[5]=0); pre-adder bypassed (OPMODE[4]=0).
- Single outstanding job; start outside IDLE has no effect.

Test Plan:
- Reset then len=3, pairs (2,3),(4,5),(-1,7), no bubbles -> result=19, res_valid rises exactly DSP_LAT+1 cycles after third accept.
- Same job with in_valid low for 2 cycles between pairs -> result=19; DSP_A/DSP_B=0 during bubbles.
- len=0 start -> res_valid next cycle with result=0; DSP_CE never asserted.
- len=255 with all pairs (-131072,-131072) -> result = 255*2^34 mod 2^48 = 0x3FC00000000.
- res_ready held low 10 cycles in DONE -> result and res_valid stable; second start ignored; after handshake busy=0.
- RSTN low mid-RUN after 2 of 5 pairs -> all outputs at reset values immediately; new len=1 job (6,7) -> result=42.

Source files
------------

// File: rtl/dsp_mac_sequencer.sv
// Multiply-accumulate sequencer for a DSP48A1 slice: streams N operand pairs into A/B,
// steers OPMODE so the first product loads P and the rest accumulate, then returns P.
module dsp_mac_sequencer #(
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned DSP_LAT = 3,
  parameter int unsigned OPM_DLY = 2
) (
  input  logic               CLK,
  input  logic               RSTN,
  input  logic               start,
  input  logic [LEN_W-1:0]   len,
  output logic               busy,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [17:0] in_a,
  input  logic signed [17:0] in_b,
  output logic [17:0]        DSP_A,
  output logic [17:0]        DSP_B,
  output logic [7:0]         DSP_OPMODE,
  output logic               DSP_CE,
  output logic               DSP_RSTP,
  input  logic [47:0]        DSP_P,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [47:0]        result
);

  localparam int unsigned CntW = (DSP_LAT < 1) ? 1 : $clog2(DSP_LAT + 1);
  // X=M, Z=0 loads the product; X=M, Z=P accumulates it.
  localparam logic [7:0] OpmLoad = 8'h01;
  localparam logic [7:0] OpmAcc  = 8'h09;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StRun,
    StDrain,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] issued_q, issued_d;
  logic [CntW-1:0]  drain_q, drain_d;
  logic [17:0]      dsp_a_q, dsp_a_d;
  logic [17:0]      dsp_b_q, dsp_b_d;
  logic             rstp_q, rstp_d;
  logic [47:0]      result_q, result_d;
  logic [7:0]       opm_issue;
  logic [7:0]       opm_pipe_q [OPM_DLY+1];
  logic             accept;

  assign in_ready = (state_q == StRun) && (issued_q < len_q);
  assign accept   = in_ready && in_valid;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    issued_d  = issued_q;
    drain_d   = drain_q;
    dsp_a_d   = '0;
    dsp_b_d   = '0;
    rstp_d    = 1'b0;
    result_d  = result_q;
    opm_issue = 8'h00;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (len != '0) begin
            len_d    = len;
            issued_d = '0;
            rstp_d   = 1'b1;
            state_d  = StClear;
          end else begin
            result_d = '0;
            state_d  = StDone;
          end
        end
      end
      StClear: begin
        opm_issue = OpmLoad;
        state_d   = StRun;
      end
      StRun: begin
        // Bubbles issue zero operands; before the first pair they load zero instead.
        opm_issue = (issued_q == '0) ? OpmLoad : OpmAcc;
        if (accept) begin
          dsp_a_d  = in_a;
          dsp_b_d  = in_b;
          issued_d = issued_q + LEN_W'(1);
          if ((issued_q + LEN_W'(1)) == len_q) begin
            drain_d = CntW'(DSP_LAT);
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        opm_issue = OpmAcc;
        if (drain_q == '0) begin
          result_d = DSP_P;
          state_d  = StDone;
        end else begin
          drain_d = drain_q - CntW'(1);
        end
      end
      StDone: begin
        if (res_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q  <= StIdle;
      len_q    <= '0;
      issued_q <= '0;
      drain_q  <= '0;
      dsp_a_q  <= '0;
      dsp_b_q  <= '0;
      rstp_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      issued_q <= issued_d;
      drain_q  <= drain_d;
      dsp_a_q  <= dsp_a_d;
      dsp_b_q  <= dsp_b_d;
      rstp_q   <= rstp_d;
      result_q <= result_d;
    end
  end

  // Stage 0 launches with A/B; the extra stages line OPMODE up with M at the post-adder.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i <= int'(OPM_DLY); i++) begin
        opm_pipe_q[i] <= 8'h00;
      end
    end else begin
      opm_pipe_q[0] <= opm_issue;
      for (int i = 1; i <= int'(OPM_DLY); i++) begin
        opm_pipe_q[i] <= opm_pipe_q[i-1];
      end
    end
  end

  assign DSP_A      = dsp_a_q;
  assign DSP_B      = dsp_b_q;
  assign DSP_OPMODE = opm_pipe_q[OPM_DLY];
  assign DSP_CE     = (state_q == StClear) || (state_q == StRun) || (state_q == StDrain);
  assign DSP_RSTP   = rstp_q;
  assign res_valid  = (state_q == StDone);
  assign result     = result_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer with a behavioural DSP48A1 slice (AREG/BREG/MREG/PREG=1).
module tb_dsp_mac_sequencer;

  localparam int LEN_W   = 8;
  localparam int DSP_LAT = 3;
  localparam int OPM_DLY = 2;

  logic               CLK = 1'b0;
  logic               RSTN = 1'b0;
  logic               start = 1'b0;
  logic [LEN_W-1:0]   len = '0;
  logic               busy;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [17:0] in_a = '0;
  logic signed [17:0] in_b = '0;
  logic [17:0]        DSP_A;
  logic [17:0]        DSP_B;
  logic [7:0]         DSP_OPMODE;
  logic               DSP_CE;
  logic               DSP_RSTP;
  logic [47:0]        DSP_P;
  logic               res_valid;
  logic               res_ready = 1'b0;
  logic [47:0]        result;

  int n_pass   = 0;
  int n_checks = 0;
  int va [256];
  int vb [256];

  dsp_mac_sequencer #(
    .LEN_W  (LEN_W),
    .DSP_LAT(DSP_LAT),
    .OPM_DLY(OPM_DLY)
  ) dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .start     (start),
    .len       (len),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .DSP_A     (DSP_A),
    .DSP_B     (DSP_B),
    .DSP_OPMODE(DSP_OPMODE),
    .DSP_CE    (DSP_CE),
    .DSP_RSTP  (DSP_RSTP),
    .DSP_P     (DSP_P),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .result    (result)
  );

  always #5 CLK = ~CLK;

  // Slice model: A/B regs, M reg, P reg with OPMODE applied combinationally at the post-adder.
  logic signed [17:0] s_a = '0;
  logic signed [17:0] s_b = '0;
  logic signed [35:0] s_m = '0;
  logic [47:0]        s_p = '0;
  always @(posedge CLK) begin
    if (DSP_CE) begin
      s_a <= DSP_A;
      s_b <= DSP_B;
      s_m <= s_a * s_b;
    end
    if (DSP_RSTP) s_p <= 48'd0;
    else if (DSP_CE)
      s_p <= ((DSP_OPMODE[3:2] == 2'b10) ? s_p : 48'd0)
           + ((DSP_OPMODE[1:0] == 2'b01) ? {{12{s_m[35]}}, s_m} : 48'd0);
  end
  assign DSP_P = s_p;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_job(input int n, input int gap, output logic [47:0] res, output int lat,
                        output int bub_bad, output bit tmo);
    int w;
    bub_bad = 0;
    tmo     = 1'b0;
    start = 1'b1;
    len   = n[LEN_W-1:0];
    @(posedge CLK); #1;
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_a = 18'(va[i]);
      in_b = 18'(vb[i]);
      w = 0;
      while (!in_ready && w < 20) begin
        @(posedge CLK); #1;
        w++;
      end
      if (!in_ready) begin
        tmo = 1'b1;
        break;
      end
      @(posedge CLK); #1;
      in_valid = 1'b0;
      if (i != n - 1) begin
        for (int g = 0; g < gap; g++) begin
          @(posedge CLK); #1;
          if (DSP_A !== 18'd0 || DSP_B !== 18'd0) bub_bad++;
        end
      end
    end
    in_valid = 1'b0;
    w = 0;
    while (!res_valid && w < 50) begin
      @(posedge CLK); #1;
      w++;
    end
    if (!res_valid) tmo = 1'b1;
    lat = w;
    res = result;
  endtask

  task automatic test_reset();
    #12;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", in_ready); else n_pass++;
    n_checks++; if (DSP_A !== 18'd0 || DSP_B !== 18'd0)
      $display("FAIL reset_ab got %h/%h want 0/0", DSP_A, DSP_B); else n_pass++;
    n_checks++; if (DSP_OPMODE !== 8'h00) $display("FAIL reset_opmode got %h want 00", DSP_OPMODE); else n_pass++;
    n_checks++; if (DSP_CE !== 1'b0 || DSP_RSTP !== 1'b0)
      $display("FAIL reset_ce_rstp got %b%b want 00", DSP_CE, DSP_RSTP); else n_pass++;
    n_checks++; if (res_valid !== 1'b0 || result !== 48'd0)
      $display("FAIL reset_result got %b/%h want 0/0", res_valid, result); else n_pass++;
    @(negedge CLK);
    RSTN = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_basic();
    logic [47:0] r; int lat; int bb; bit tmo;
    va[0] = 2;  vb[0] = 3;
    va[1] = 4;  vb[1] = 5;
    va[2] = -1; vb[2] = 7;
    do_job(3, 0, r, lat, bb, tmo);
    n_checks++; if (tmo) $display("FAIL basic_timeout got timeout want completion"); else n_pass++;
    n_checks++; if (r !== 48'd19) $display("FAIL basic_result got %0d want 19", r); else n_pass++;
    n_checks++; if (lat != DSP_LAT + 1) $display("FAIL basic_latency got %0d want %0d", lat, DSP_LAT + 1); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL basic_busy_done got %b want 1", busy); else n_pass++;
    res_ready = 1'b1;
    @(posedge CLK); #1;
    res_ready = 1'b0;
    n_checks++; if (busy !== 1'b0 || res_valid !== 1'b0)
      $display("FAIL basic_handshake got busy=%b valid=%b want 0/0", busy, res_valid); else n_pass++;
  endtask

  task automatic test_bubbles();
    logic [47:0] r; int lat; int bb; bit tmo;
    do_job(3, 2, r, lat, bb, tmo);
    n_checks++; if (r !== 48'd19 || tmo) $display("FAIL bubble_result got %0d want 19", r); else n_pass++;
    n_checks++; if (bb != 0) $display("FAIL bubble_zero_ab got %0d nonzero want 0", bb); else n_pass++;
    res_ready = 1'b1;
    @(posedge CLK); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_len_zero();
    int ce_seen = 0;
    start = 1'b1;
    len   = '0;
    if (DSP_CE) ce_seen++;
    @(posedge CLK); #1;
    start = 1'b0;
    if (DSP_CE) ce_seen++;
    n_checks++; if (res_valid !== 1'b1) $display("FAIL len0_valid got %b want 1", res_valid); else n_pass++;
    n_checks++; if (result !== 48'd0) $display("FAIL len0_result got %0d want 0", result); else n_pass++;
    res_ready = 1'b1;
    @(posedge CLK); #1;
    res_ready = 1'b0;
    if (DSP_CE) ce_seen++;
    n_checks++; if (ce_seen != 0) $display("FAIL len0_ce got %0d cycles want 0", ce_seen); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL len0_idle got busy=%b want 0", busy); else n_pass++;
  endtask

  task automatic test_long();
    logic [47:0] r; int lat; int bb; bit tmo;
    for (int i = 0; i < 255; i++) begin
      va[i] = -131072;
      vb[i] = -131072;
    end
    do_job(255, 0, r, lat, bb, tmo);
    n_checks++; if (r !== 48'h03FC_0000_0000 || tmo)
      $display("FAIL long_result got %h want 03fc00000000", r); else n_pass++;
    n_checks++; if (lat != DSP_LAT + 1) $display("FAIL long_latency got %0d want %0d", lat, DSP_LAT + 1); else n_pass++;
    res_ready = 1'b1;
    @(posedge CLK); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_back_to_back_hold();
    logic [47:0] r; int lat; int bb; bit tmo; int unstable = 0;
    va[0] = 2;  vb[0] = 3;
    va[1] = 4;  vb[1] = 5;
    va[2] = -1; vb[2] = 7;
    do_job(3, 0, r, lat, bb, tmo);
    for (int c = 0; c < 10; c++) begin
      start = (c < 4);
      len   = 8'd5;
      @(posedge CLK); #1;
      if (res_valid !== 1'b1 || result !== 48'd19 || in_ready !== 1'b0) unstable++;
    end
    start = 1'b0;
    n_checks++; if (unstable != 0) $display("FAIL hold_stable got %0d bad cycles want 0", unstable); else n_pass++;
    res_ready = 1'b1;
    @(posedge CLK); #1;
    res_ready = 1'b0;
    n_checks++; if (res_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL hold_release got valid=%b busy=%b want 0/0", res_valid, busy); else n_pass++;
    @(posedge CLK); #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL hold_no_queued_start got busy=%b want 0", busy); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [47:0] r; int lat; int bb; bit tmo; int w;
    start = 1'b1;
    len   = 8'd5;
    @(posedge CLK); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_a = 18'(i + 3);
      in_b = 18'(i + 9);
      w = 0;
      while (!in_ready && w < 20) begin
        @(posedge CLK); #1;
        w++;
      end
      @(posedge CLK); #1;
    end
    #2;
    RSTN = 1'b0;
    #1;
    in_valid = 1'b0;
    n_checks++; if (busy !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL midrst_ctrl got busy=%b rdy=%b want 0/0", busy, in_ready); else n_pass++;
    n_checks++; if (DSP_A !== 18'd0 || DSP_B !== 18'd0 || DSP_OPMODE !== 8'h00)
      $display("FAIL midrst_dsp got %h/%h/%h want 0/0/0", DSP_A, DSP_B, DSP_OPMODE); else n_pass++;
    n_checks++; if (DSP_CE !== 1'b0 || res_valid !== 1'b0 || result !== 48'd0)
      $display("FAIL midrst_out got ce=%b valid=%b res=%h want 0/0/0", DSP_CE, res_valid, result);
    else n_pass++;
    @(negedge CLK);
    @(negedge CLK);
    RSTN = 1'b1;
    @(posedge CLK); #1;
    va[0] = 6;
    vb[0] = 7;
    do_job(1, 0, r, lat, bb, tmo);
    n_checks++; if (r !== 48'd42 || tmo) $display("FAIL midrst_newjob got %0d want 42", r); else n_pass++;
    n_checks++; if (lat != DSP_LAT + 1) $display("FAIL midrst_latency got %0d want %0d", lat, DSP_LAT + 1); else n_pass++;
    res_ready = 1'b1;
    @(posedge CLK); #1;
    res_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bubbles();
    test_len_zero();
    test_long();
    test_back_to_back_hold();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
